// File: rtl/flop_write_arbiter.sv
// flop_write_arbiter
// Round-robin arbiter and write sequencer for one shared register.
// Requesters raise req, receive a one-cycle one-hot gnt, and the register
// loads the owner's data on the following edge. A programmable cool-down gap
// follows each completed write. All outputs come straight from flops.

module flop_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter int COOL_CYC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  input  logic                     clr,
  output logic [N_REQ-1:0]         gnt,
  output logic [2:0]               owner,
  output logic [WIDTH-1:0]         y,
  output logic                     busy,
  output logic                     done
);

  // The cool counter holds COOL_CYC-1 down to 0, so it never needs to
  // represent COOL_CYC itself.
  localparam int CNT_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  // Registered state
  state_t             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [2:0]         r_owner;
  logic [WIDTH-1:0]   r_y;
  logic               r_busy;
  logic               r_done;
  logic [2:0]         r_rrPtr;
  logic [CNT_W-1:0]   r_coolCnt;

  // Combinational helpers
  logic               w_anyReq;
  logic [2:0]         w_winner;
  logic [2:0]         w_winnerInc;
  logic [N_REQ-1:0]   w_winnerOneHot;
  logic               w_ownerReq;
  logic [WIDTH-1:0]   w_ownerData;

  // Next-state values
  state_t             w_stateNext;
  logic [N_REQ-1:0]   w_gntNext;
  logic [2:0]         w_ownerNext;
  logic [WIDTH-1:0]   w_yNext;
  logic               w_doneNext;
  logic [2:0]         w_ptrNext;
  logic [CNT_W-1:0]   w_cntNext;

  assign w_anyReq = |req;

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    logic found;
    found    = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(r_rrPtr) + k) % N_REQ))) begin
          found    = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  // Decode the winner into a one-hot grant and the pointer that follows it.
  always_comb begin
    w_winnerOneHot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == 3'(i)) begin
        w_winnerOneHot[i] = 1'b1;
      end
    end
    w_winnerInc = (w_winner == 3'(N_REQ - 1)) ? 3'd0 : (w_winner + 3'd1);
  end

  // Select the current owner's request level and data lane.
  always_comb begin
    w_ownerReq  = 1'b0;
    w_ownerData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == 3'(i)) begin
        w_ownerReq  = req[i];
        w_ownerData = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic; clr overrides everything except the
  // pointer and the owner index.
  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = '0;
    w_ownerNext = r_owner;
    w_yNext     = r_y;
    w_doneNext  = 1'b0;
    w_ptrNext   = r_rrPtr;
    w_cntNext   = r_coolCnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          w_stateNext = ST_WRITE;
          w_gntNext   = w_winnerOneHot;
          w_ownerNext = w_winner;
          w_ptrNext   = w_winnerInc;
        end
      end

      ST_WRITE: begin
        if (w_ownerReq) begin
          w_yNext    = w_ownerData;
          w_doneNext = 1'b1;
          if (COOL_CYC == 0) begin
            w_stateNext = ST_IDLE;
          end else begin
            w_stateNext = ST_COOL;
            w_cntNext   = COOL_LOAD;
          end
        end else begin
          w_stateNext = ST_IDLE;
        end
      end

      ST_COOL: begin
        if (r_coolCnt == '0) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_coolCnt - 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    if (clr) begin
      w_stateNext = ST_IDLE;
      w_gntNext   = '0;
      w_yNext     = '0;
      w_doneNext  = 1'b0;
      w_cntNext   = '0;
      w_ownerNext = r_owner;
      w_ptrNext   = r_rrPtr;
    end
  end

  // State and output registers; busy is derived from the next state so it
  // changes on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_y       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rrPtr   <= '0;
      r_coolCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_gnt     <= w_gntNext;
      r_owner   <= w_ownerNext;
      r_y       <= w_yNext;
      r_busy    <= (w_stateNext != ST_IDLE);
      r_done    <= w_doneNext;
      r_rrPtr   <= w_ptrNext;
      r_coolCnt <= w_cntNext;
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign y     = r_y;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_flop_write_arbiter.sv
// Testbench for flop_write_arbiter.
// Instance A uses a one-cycle cool-down, instance B has no cool-down.
// Expected grants and loaded values are queued by the stimulus and consumed
// by per-instance monitors whenever gnt or done appears.

module tb_flop_write_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;

  logic [N_REQ-1:0]       reqA, gntA, reqB, gntB;
  logic [N_REQ*WIDTH-1:0] wdataA, wdataB;
  logic                   clrA, clrB;
  logic [2:0]             ownerA, ownerB;
  logic [WIDTH-1:0]       yA, yB;
  logic                   busyA, busyB, doneA, doneB;

  typedef struct {
    logic [3:0] gnt;
    logic [2:0] owner;
    int         gap;
  } gntExp_t;

  gntExp_t    gntQA[$];
  gntExp_t    gntQB[$];
  logic [3:0] yQA[$];
  logic [3:0] yQB[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lastGntA = 0;
  int lastGntB = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  flop_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .COOL_CYC(1)) dutA (
    .clk(clk), .reset(reset), .req(reqA), .wdata(wdataA), .clr(clrA),
    .gnt(gntA), .owner(ownerA), .y(yA), .busy(busyA), .done(doneA)
  );

  flop_write_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .COOL_CYC(0)) dutB (
    .clk(clk), .reset(reset), .req(reqB), .wdata(wdataB), .clr(clrB),
    .gnt(gntB), .owner(ownerB), .y(yB), .busy(busyB), .done(doneB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d);
    reqA   = r;
    wdataA = d;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expGntA(input logic [3:0] g, input logic [2:0] o, input int gap);
    gntExp_t e;
    e.gnt = g; e.owner = o; e.gap = gap;
    gntQA.push_back(e);
  endtask

  task automatic expGntB(input logic [3:0] g, input logic [2:0] o, input int gap);
    gntExp_t e;
    e.gnt = g; e.owner = o; e.gap = gap;
    gntQB.push_back(e);
  endtask

  // Monitor for instance A: consumes expectations on each grant and done.
  always begin : monA
    gntExp_t e;
    @(posedge clk);
    #1;
    if (gntA != '0) begin
      checkOutput("gntA_onehot", 32'($onehot0(gntA)), 32'd1);
      if (gntQA.size() == 0) begin
        checkOutput("gntA_unexpected", 32'(gntA), 32'd0);
      end else begin
        e = gntQA.pop_front();
        checkOutput("gntA", 32'(gntA), 32'(e.gnt));
        checkOutput("ownerA", 32'(ownerA), 32'(e.owner));
        if (e.gap != 0) checkOutput("gapA", 32'(cyc - lastGntA), 32'(e.gap));
      end
      lastGntA = cyc;
    end
    if (doneA) begin
      if (yQA.size() == 0) checkOutput("doneA_unexpected", 32'(doneA), 32'd0);
      else                 checkOutput("yA_on_done", 32'(yA), 32'(yQA.pop_front()));
    end
  end

  // Monitor for instance B: same scheme as A.
  always begin : monB
    gntExp_t e;
    @(posedge clk);
    #1;
    if (gntB != '0) begin
      checkOutput("gntB_onehot", 32'($onehot0(gntB)), 32'd1);
      if (gntQB.size() == 0) begin
        checkOutput("gntB_unexpected", 32'(gntB), 32'd0);
      end else begin
        e = gntQB.pop_front();
        checkOutput("gntB", 32'(gntB), 32'(e.gnt));
        checkOutput("ownerB", 32'(ownerB), 32'(e.owner));
        if (e.gap != 0) checkOutput("gapB", 32'(cyc - lastGntB), 32'(e.gap));
      end
      lastGntB = cyc;
    end
    if (doneB) begin
      if (yQB.size() == 0) checkOutput("doneB_unexpected", 32'(doneB), 32'd0);
      else                 checkOutput("yB_on_done", 32'(yB), 32'(yQB.pop_front()));
    end
  end

  initial begin
    reset  = 1'b1;
    reqA   = '0; wdataA = '0; clrA = 1'b0;
    reqB   = '0; wdataB = '0; clrB = 1'b0;

    // Reset state
    waitNeg(2);
    checkOutput("rst_gnt",   32'(gntA),   32'd0);
    checkOutput("rst_owner", 32'(ownerA), 32'd0);
    checkOutput("rst_y",     32'(yA),     32'd0);
    checkOutput("rst_busy",  32'(busyA),  32'd0);
    checkOutput("rst_done",  32'(doneA),  32'd0);
    reset = 1'b0;
    waitNeg(2);

    // Single write from requester 0
    expGntA(4'b0001, 3'd0, 0);
    yQA.push_back(4'hE);
    applyStimulus(4'b0001, 16'h000E);
    waitNeg(2);
    applyStimulus(4'b0000, 16'h0000);
    waitNeg(3);
    checkOutput("t1_y", 32'(yA), 32'hE);
    checkOutput("t1_busy", 32'(busyA), 32'd0);

    // All requesters held; pointer starts at 1 after the first write
    expGntA(4'b0010, 3'd1, 0);
    expGntA(4'b0100, 3'd2, 3);
    expGntA(4'b1000, 3'd3, 3);
    expGntA(4'b0001, 3'd0, 3);
    expGntA(4'b0010, 3'd1, 3);
    yQA.push_back(4'hC);
    yQA.push_back(4'h5);
    yQA.push_back(4'hA);
    yQA.push_back(4'h3);
    yQA.push_back(4'hC);
    applyStimulus(4'b1111, 16'hA5C3);
    waitNeg(14);
    applyStimulus(4'b0000, 16'h0000);
    waitNeg(3);

    // clr during WRITE discards the load; next grant follows the pointer
    expGntA(4'b0100, 3'd2, 0);
    applyStimulus(4'b0100, 16'h0100);
    waitNeg(1);
    clrA = 1'b1;
    waitNeg(1);
    clrA = 1'b0;
    checkOutput("t3_clr_y", 32'(yA), 32'd0);
    checkOutput("t3_clr_busy", 32'(busyA), 32'd0);
    checkOutput("t3_clr_gnt", 32'(gntA), 32'd0);
    expGntA(4'b1000, 3'd3, 0);
    yQA.push_back(4'h7);
    applyStimulus(4'b1100, 16'h7100);
    waitNeg(2);
    applyStimulus(4'b0000, 16'h0000);
    waitNeg(3);
    checkOutput("t3_y", 32'(yA), 32'h7);

    // Requester drops during its WRITE cycle: no load, straight to IDLE
    expGntA(4'b0010, 3'd1, 0);
    applyStimulus(4'b0010, 16'h0090);
    waitNeg(1);
    applyStimulus(4'b0000, 16'h0000);
    waitNeg(1);
    checkOutput("t4_y", 32'(yA), 32'h7);
    checkOutput("t4_busy", 32'(busyA), 32'd0);
    waitNeg(2);

    // Asynchronous reset in the middle of COOL
    expGntA(4'b0100, 3'd2, 0);
    yQA.push_back(4'h1);
    applyStimulus(4'b0100, 16'h0100);
    waitNeg(2);
    checkOutput("t5_cool_busy", 32'(busyA), 32'd1);
    checkOutput("t5_cool_y", 32'(yA), 32'h1);
    applyStimulus(4'b0000, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_async_y",     32'(yA),     32'd0);
    checkOutput("t5_async_gnt",   32'(gntA),   32'd0);
    checkOutput("t5_async_busy",  32'(busyA),  32'd0);
    checkOutput("t5_async_done",  32'(doneA),  32'd0);
    checkOutput("t5_async_owner", 32'(ownerA), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitNeg(2);

    // No cool-down: two requesters alternate every two cycles
    expGntB(4'b0001, 3'd0, 0);
    expGntB(4'b0100, 3'd2, 2);
    expGntB(4'b0001, 3'd0, 2);
    expGntB(4'b0100, 3'd2, 2);
    yQB.push_back(4'h6);
    yQB.push_back(4'hB);
    yQB.push_back(4'h6);
    yQB.push_back(4'hB);
    reqB   = 4'b0101;
    wdataB = 16'h0B06;
    waitNeg(8);
    reqB = 4'b0000;
    waitNeg(3);
    checkOutput("t6_y", 32'(yB), 32'hB);
    checkOutput("t6_busy", 32'(busyB), 32'd0);

    // Every queued expectation must have been consumed
    checkOutput("gntQA_left", 32'(gntQA.size()), 32'd0);
    checkOutput("yQA_left",   32'(yQA.size()),   32'd0);
    checkOutput("gntQB_left", 32'(gntQB.size()), 32'd0);
    checkOutput("yQB_left",   32'(yQB.size()),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
